phys_reg_free_list: RTL and testbench
=====================================

PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL have parameter NUM_P_REGS, default 64, the number of physical registers.
REQ-002 SHALL have parameter NUM_A_REGS, default 32, the number of architectural registers; free-list depth FL_DEPTH = NUM_P_REGS - NUM_A_REGS.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports clk_i and rst_i.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 alloc0_req_i / alloc1_req_i  in  1 each  rename slot 0/1 requests a destination physical register this cycle.
REQ-007 alloc_preg0_o / alloc_preg1_o  out  $clog2(NUM_P_REGS) each  granted register for slot 0/1; combinational peek.
REQ-008 free_low_o  out  1  fewer than two registers free; dispatch SHALL NOT issue two allocations while it is high.
REQ-009 free_count_o  out  $clog2(FL_DEPTH+1)  current number of free registers.
REQ-010 en_retire_dest0_i / en_retire_dest1_i  in  1 each  ROB retire port 0/1 releases a register.
REQ-011 retire_old_dest0_i / retire_old_dest1_i  in  $clog2(NUM_P_REGS) each  physical register released by port 0/1.
REQ-012 double_free_o  out  1  error pulse; present only with FREE_LIST_CHECK_EN.

Function
REQ-013 SHALL hold free registers in a FL_DEPTH-entry circular FIFO with head, tail and count; head and tail wrap modulo FL_DEPTH.
REQ-014 alloc_preg0_o SHALL equal list[head]; alloc_preg1_o SHALL equal list[head+1] when alloc0_req_i is high, else list[head].
REQ-015 Requested count N = alloc0_req_i + alloc1_req_i; if N <= count, head SHALL advance by N at the edge; if N > count, no allocation SHALL occur (all-or-nothing) and head is unchanged.
REQ-016 Released registers SHALL be pushed at tail in order port 0 then port 1; tail advances by the number accepted.
REQ-017 A release of physical register 0 SHALL be ignored (x0 permanently mapped).
REQ-018 Released registers SHALL NOT be allocatable in the same cycle; allocation uses pre-edge state only.
REQ-019 Next count SHALL equal count - granted + accepted frees, for simultaneous allocate and free.
REQ-020 A release that would exceed FL_DEPTH SHALL be dropped.
REQ-021 free_low_o SHALL equal (count < 2), combinational from registered count.
REQ-022 Latency: a granted register is removed at the edge; a freed register is visible at alloc outputs no earlier than the next cycle.

Reset
REQ-023 On rst_i at an edge, list[i] SHALL be set to NUM_A_REGS+i for i = 0..FL_DEPTH-1; head = 0, tail = 0, count = FL_DEPTH.
REQ-024 All alloc and release inputs SHALL be ignored in a reset cycle, including reset mid-operation.
REQ-025 After reset, free_count_o = FL_DEPTH, free_low_o = 0, alloc_preg0_o = NUM_A_REGS, double_free_o = 0.

Configuration
REQ-026 Macro FREE_LIST_CHECK_EN SHALL enable a NUM_P_REGS-bit "is free" bitmap, set on accept and cleared on grant, and reset to match REQ-023.
REQ-027 With FREE_LIST_CHECK_EN, a release of a register already free, or of two identical registers in one cycle (second one), SHALL be dropped, and double_free_o SHALL pulse high for one cycle; an overflow drop per REQ-020 also pulses it.
REQ-028 Without FREE_LIST_CHECK_EN, no bitmap and no double_free_o port SHALL exist; duplicate releases are pushed unchecked.

Structure
REQ-029 NUM_P_REGS, NUM_A_REGS and a preg_t typedef of $clog2(NUM_P_REGS) bits SHALL live in shared package rename_pkg, shared with the ROB and rename table.
REQ-030 No sub-module is warranted; FIFO and bitmap are inline.

Verification
REQ-031 Reset, then alloc0+alloc1 -> grants p32, p33; next cycle free_count_o = 30, alloc_preg0_o = p34.
REQ-032 Allocate 31, then free p5 (port 0) and p7 (port 1) in one cycle -> count 1 -> 3; after draining p63, subsequent grants are p5, then p7 (wrap-around).
REQ-033 count = 1 with alloc0+alloc1 -> no grant, count stays 1; alloc0 alone -> grant, count 0, free_low_o = 1.
REQ-034 count = 0, alloc0+alloc1 with frees p9, p10 in the same cycle -> no grant; next cycle count 2, alloc_preg0_o = p9, alloc_preg1_o = p10.
REQ-035 With FREE_LIST_CHECK_EN, after reset free p40 -> double_free_o = 1 for one cycle, count stays 32; free p0 -> ignored, no error.
REQ-036 Assert rst_i mid-stream with alloc and free active -> next cycle count = 32, alloc_preg0_o = p32.

Source files
------------

// File: rtl/rename_pkg.sv
// -----------------------------------------------------------------------------
// rename_pkg
// Shared rename-stage definitions used by the free list, the ROB and the
// rename table.
//   NUM_P_REGS : number of physical registers
//   NUM_A_REGS : number of architectural registers (p0..p(NUM_A_REGS-1) hold
//                the initial architectural mapping)
//   preg_t     : physical register index type
//   wrap_add   : circular-buffer pointer increment helper
// -----------------------------------------------------------------------------
package rename_pkg;

    localparam int NUM_P_REGS = 64;
    localparam int NUM_A_REGS = 32;

    typedef logic [$clog2(NUM_P_REGS)-1:0] preg_t;

    // Advance a circular pointer by a small step; depth need not be a power
    // of two, so the wrap is an explicit compare-and-subtract.
    function automatic int wrap_add(input int base, input int inc, input int depth);
        int sum;
        sum = base + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list
// Circular FIFO of free physical registers for a two-wide rename stage.
// Two allocation slots peek at the head; two ROB retire ports push released
// registers at the tail. Allocation is all-or-nothing and only sees state
// from before the clock edge, so a register released this cycle can first
// be handed out next cycle.
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 synchronous active-high reset
//   alloc0_req_i/1        rename slot 0/1 wants a destination register
//   alloc_preg0_o/1       register offered to slot 0/1 (combinational)
//   free_low_o            fewer than two registers free
//   free_count_o          number of free registers
//   en_retire_dest0_i/1   retire port 0/1 releases a register
//   retire_old_dest0_i/1  register released by port 0/1
//   double_free_o         one-cycle error pulse (FREE_LIST_CHECK_EN only)
//
// Build option
//   FREE_LIST_CHECK_EN : adds an "is free" bitmap that drops releases of
//                        registers that are already free (or repeated within
//                        one cycle) and flags them, together with overflow
//                        drops, on double_free_o.
// -----------------------------------------------------------------------------
module phys_reg_free_list #(
    parameter int NUM_P_REGS = rename_pkg::NUM_P_REGS,
    parameter int NUM_A_REGS = rename_pkg::NUM_A_REGS
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        alloc0_req_i,
    input  logic                                        alloc1_req_i,
    output logic [$clog2(NUM_P_REGS)-1:0]               alloc_preg0_o,
    output logic [$clog2(NUM_P_REGS)-1:0]               alloc_preg1_o,
    output logic                                        free_low_o,
    output logic [$clog2(NUM_P_REGS-NUM_A_REGS+1)-1:0]  free_count_o,
    input  logic                                        en_retire_dest0_i,
    input  logic                                        en_retire_dest1_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]               retire_old_dest0_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]               retire_old_dest1_i
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic                                        double_free_o
`endif
);

    localparam int FL_DEPTH = NUM_P_REGS - NUM_A_REGS;
    localparam int PREG_W   = $clog2(NUM_P_REGS);
    localparam int PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FL_DEPTH + 1);

    logic [PREG_W-1:0] list [FL_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [PTR_W-1:0]  head_p1;
    logic [PTR_W-1:0]  tail_p1;
    logic [PTR_W-1:0]  tail_w1;
    logic [PTR_W-1:0]  head_next;
    logic [PTR_W-1:0]  tail_next;
    logic [CNT_W-1:0]  count_next;
    logic              grant_ok;
    logic              valid0;
    logic              valid1;
    logic              cand0;
    logic              cand1;
    logic              acc0;
    logic              acc1;
    int                n_req;
    int                n_grant;
    int                n_acc;
    int                cnt_after_grant;

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_P_REGS-1:0] is_free;
    logic                  grant0;
    logic                  grant1;
    logic                  drop_err;
`endif

    // Grant and release decisions. Everything here reads pre-edge state only,
    // so a register released this cycle can never be offered this cycle.
    // Releases fill the slots left after this cycle's grants, which is why
    // the overflow test uses the post-grant count.
    always_comb begin
        head_p1         = PTR_W'(rename_pkg::wrap_add(int'(head), 1, FL_DEPTH));
        tail_p1         = PTR_W'(rename_pkg::wrap_add(int'(tail), 1, FL_DEPTH));
        alloc_preg0_o   = list[head];
        alloc_preg1_o   = alloc0_req_i ? list[head_p1] : list[head];
        free_low_o      = (count < CNT_W'(2));
        free_count_o    = count;

        n_req           = int'(alloc0_req_i) + int'(alloc1_req_i);
        grant_ok        = (n_req <= int'(count));
        n_grant         = grant_ok ? n_req : 0;
        cnt_after_grant = int'(count) - n_grant;

        valid0          = en_retire_dest0_i && (retire_old_dest0_i != '0);
        valid1          = en_retire_dest1_i && (retire_old_dest1_i != '0);
`ifdef FREE_LIST_CHECK_EN
        cand0           = valid0 && !is_free[retire_old_dest0_i];
        cand1           = valid1 && !is_free[retire_old_dest1_i] &&
                          !(en_retire_dest0_i && (retire_old_dest0_i == retire_old_dest1_i));
`else
        cand0           = valid0;
        cand1           = valid1;
`endif
        acc0            = cand0 && (cnt_after_grant < FL_DEPTH);
        acc1            = cand1 && ((cnt_after_grant + int'(acc0)) < FL_DEPTH);
        n_acc           = int'(acc0) + int'(acc1);

        tail_w1         = acc0 ? tail_p1 : tail;
        head_next       = PTR_W'(rename_pkg::wrap_add(int'(head), n_grant, FL_DEPTH));
        tail_next       = PTR_W'(rename_pkg::wrap_add(int'(tail), n_acc, FL_DEPTH));
        count_next      = CNT_W'(cnt_after_grant + n_acc);

`ifdef FREE_LIST_CHECK_EN
        grant0          = grant_ok && alloc0_req_i;
        grant1          = grant_ok && alloc1_req_i;
        drop_err        = (valid0 && !acc0) || (valid1 && !acc1);
`endif
    end

    // FIFO storage and pointers. Reset reloads the list with the registers
    // that are not part of the initial architectural mapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                list[i] <= PREG_W'(NUM_A_REGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FL_DEPTH);
        end else begin
            if (acc0) begin
                list[tail] <= retire_old_dest0_i;
            end
            if (acc1) begin
                list[tail_w1] <= retire_old_dest1_i;
            end
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    // Membership bitmap mirroring the FIFO contents. Grants clear before
    // accepts set; a register being granted this cycle still reads as free,
    // so releasing it in the same cycle is reported as a double free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_P_REGS; i++) begin
                is_free[i] <= (i >= NUM_A_REGS);
            end
            double_free_o <= 1'b0;
        end else begin
            if (grant0) begin
                is_free[alloc_preg0_o] <= 1'b0;
            end
            if (grant1) begin
                is_free[alloc_preg1_o] <= 1'b0;
            end
            if (acc0) begin
                is_free[retire_old_dest0_i] <= 1'b1;
            end
            if (acc1) begin
                is_free[retire_old_dest1_i] <= 1'b1;
            end
            double_free_o <= drop_err;
        end
    end
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// tb_phys_reg_free_list
// Self-checking bench for phys_reg_free_list. The reference model keeps the
// free registers in a queue (front = next to allocate) and the registers
// currently in use in a second queue from which releases are drawn.
// Honours FREE_LIST_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_phys_reg_free_list;

    localparam int NP    = 64;
    localparam int NA    = 32;
    localparam int DEPTH = NP - NA;

    logic       clk;
    logic       rst;
    logic       alloc0;
    logic       alloc1;
    logic [5:0] preg0;
    logic [5:0] preg1;
    logic       freeLow;
    logic [5:0] freeCount;
    logic       en0;
    logic       en1;
    logic [5:0] old0;
    logic [5:0] old1;
`ifdef FREE_LIST_CHECK_EN
    logic       doubleFree;
`endif

    int checks;
    int errors;
    int freeQ[$];
    int heldQ[$];
    int expDfree;
    bit modelValid;

    phys_reg_free_list #(
        .NUM_P_REGS(NP),
        .NUM_A_REGS(NA)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .alloc0_req_i       (alloc0),
        .alloc1_req_i       (alloc1),
        .alloc_preg0_o      (preg0),
        .alloc_preg1_o      (preg1),
        .free_low_o         (freeLow),
        .free_count_o       (freeCount),
        .en_retire_dest0_i  (en0),
        .en_retire_dest1_i  (en1),
        .retire_old_dest0_i (old0),
        .retire_old_dest1_i (old1)
`ifdef FREE_LIST_CHECK_EN
        ,
        .double_free_o      (doubleFree)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit inFree(input int r);
        foreach (freeQ[k]) begin
            if (freeQ[k] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic removeHeld(input int r);
        foreach (heldQ[k]) begin
            if (heldQ[k] == r) begin
                heldQ.delete(k);
                return;
            end
        end
    endtask

    // Compare every observable output against the model's pre-edge view.
    task automatic checkCycle();
        if (!modelValid) return;
        checkOutput("free_count", int'(freeCount), freeQ.size());
        checkOutput("free_low", int'(freeLow), (freeQ.size() < 2) ? 1 : 0);
        if (freeQ.size() > 0) begin
            checkOutput("alloc_preg0", int'(preg0), freeQ[0]);
        end
        if (alloc0 && freeQ.size() >= 2) begin
            checkOutput("alloc_preg1", int'(preg1), freeQ[1]);
        end else if (!alloc0 && freeQ.size() >= 1) begin
            checkOutput("alloc_preg1", int'(preg1), freeQ[0]);
        end
`ifdef FREE_LIST_CHECK_EN
        checkOutput("double_free", int'(doubleFree), expDfree);
`endif
    endtask

    // Advance the model by one clock edge using the rules of the free list.
    task automatic modelUpdate(input bit a0, input bit a1, input bit e0, input int r0,
                               input bit e1, input int r1, input bit rs);
        int  n;
        bit  acc0;
        bit  acc1;
        bit  err;
        if (rs) begin
            freeQ.delete();
            heldQ.delete();
            for (int i = 0; i < DEPTH; i++) freeQ.push_back(NA + i);
            for (int i = 1; i < NA; i++) heldQ.push_back(i);
            expDfree   = 0;
            modelValid = 1'b1;
            return;
        end
        n    = int'(a0) + int'(a1);
        acc0 = e0 && (r0 != 0);
        acc1 = e1 && (r1 != 0);
        err  = 1'b0;
`ifdef FREE_LIST_CHECK_EN
        if (acc0 && inFree(r0)) begin
            acc0 = 1'b0;
            err  = 1'b1;
        end
        if (acc1 && (inFree(r1) || (e0 && r0 == r1))) begin
            acc1 = 1'b0;
            err  = 1'b1;
        end
`endif
        if (n <= freeQ.size()) begin
            for (int k = 0; k < n; k++) heldQ.push_back(freeQ.pop_front());
        end
        if (acc0) begin
            if (freeQ.size() < DEPTH) begin
                freeQ.push_back(r0);
                removeHeld(r0);
            end else begin
                err = 1'b1;
            end
        end
        if (acc1) begin
            if (freeQ.size() < DEPTH) begin
                freeQ.push_back(r1);
                removeHeld(r1);
            end else begin
                err = 1'b1;
            end
        end
        expDfree = int'(err);
    endtask

    // Drive one cycle of inputs, check pre-edge outputs, then step the model.
    task automatic applyStimulus(input bit a0, input bit a1, input bit e0, input int r0,
                                 input bit e1, input int r1, input bit rs);
        @(negedge clk);
        rst    = rs;
        alloc0 = a0;
        alloc1 = a1;
        en0    = e0;
        en1    = e1;
        old0   = 6'(r0);
        old1   = 6'(r1);
        #1;
        checkCycle();
        @(posedge clk);
        modelUpdate(a0, a1, e0, r0, e1, r1, rs);
    endtask

    function automatic int pickRelease();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 8 && heldQ.size() > 0) return heldQ[$urandom_range(0, heldQ.size() - 1)];
        if (sel == 8) return 0;
        return $urandom_range(0, NP - 1);
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        expDfree   = 0;
        modelValid = 1'b0;
        rst = 1'b0; alloc0 = 1'b0; alloc1 = 1'b0;
        en0 = 1'b0; en1 = 1'b0; old0 = '0; old1 = '0;

        // Reset state
        applyStimulus(1, 1, 1, 5, 1, 6, 1);
        #2;
        checkOutput("rst_count", int'(freeCount), 32);
        checkOutput("rst_low", int'(freeLow), 0);
        checkOutput("rst_preg0", int'(preg0), 32);
`ifdef FREE_LIST_CHECK_EN
        checkOutput("rst_dfree", int'(doubleFree), 0);
`endif

        // Dual grant of p32/p33
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        #2;
        checkOutput("dual_count", int'(freeCount), 30);
        checkOutput("dual_preg0", int'(preg0), 34);

        // Drain to one entry (p63), then release p5/p7 and wrap around
        for (int i = 0; i < 14; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("drain_count", int'(freeCount), 1);
        checkOutput("drain_preg0", int'(preg0), 63);
        applyStimulus(0, 0, 1, 5, 1, 7, 0);
        #2;
        checkOutput("free2_count", int'(freeCount), 3);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("wrap_preg0", int'(preg0), 5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("wrap2_preg0", int'(preg0), 7);

        // All-or-nothing at count 1, then exhaust
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        #2;
        checkOutput("aon_count", int'(freeCount), 1);
        checkOutput("aon_preg0", int'(preg0), 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("empty_count", int'(freeCount), 0);
        checkOutput("empty_low", int'(freeLow), 1);

        // Frees at count 0 are not allocatable in the same cycle
        applyStimulus(1, 1, 1, 9, 1, 10, 0);
        #2;
        checkOutput("refill_count", int'(freeCount), 2);
        checkOutput("refill_preg0", int'(preg0), 9);
        alloc0 = 1'b1;
        #1;
        checkOutput("refill_preg1", int'(preg1), 10);

        // Release of an already-free register and of p0
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 40, 0, 0, 0);
        #2;
        checkOutput("dup_count", int'(freeCount), 32);
`ifdef FREE_LIST_CHECK_EN
        checkOutput("dup_dfree", int'(doubleFree), 1);
`endif
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        #2;
        checkOutput("p0_count", int'(freeCount), 32);
`ifdef FREE_LIST_CHECK_EN
        checkOutput("p0_dfree", int'(doubleFree), 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), pickRelease(),
                          1'($urandom_range(0, 1)), pickRelease(), 0);
        end

        // Reset in the middle of traffic
        applyStimulus(1, 1, 1, pickRelease(), 1, pickRelease(), 1);
        #2;
        checkOutput("midrst_count", int'(freeCount), 32);
        checkOutput("midrst_preg0", int'(preg0), 32);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
